// File: rtl/ram_arbiter_if.sv
// Two-requester RAM arbiter bus: requester ports m0/m1 plus the single-port RAM side.
// The slave modport is the arbiter's view; master is the requester/RAM environment view.
interface ram_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              m0_req,    m1_req;
  logic              m0_we,     m1_we;
  logic [ADDR_W-1:0] m0_addr,   m1_addr;
  logic [DATA_W-1:0] m0_wdata,  m1_wdata;
  logic              m0_gnt,    m1_gnt;
  logic              m0_rvalid, m1_rvalid;
  logic [DATA_W-1:0] m0_rdata,  m1_rdata;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;
  logic              busy;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output ram_we, ram_addr, ram_din,
    input  ram_dout,
    output busy
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  ram_we, ram_addr, ram_din,
    output ram_dout,
    input  busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter onto a single registered-output RAM, one access every 3 cycles.
// Define ARB_ROUND_ROBIN_EN for alternating grants on contention; default is fixed m0 priority.
module ram_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input logic           clk,
  input logic           rst,
  ram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state, state_nxt;
  logic              any_req;
  logic              pick;      // port chosen this cycle: 0 = m0, 1 = m1
  logic              sel;       // port owning the access in flight
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_din;
  logic [DATA_W-1:0] rdata0, rdata1;

  assign any_req = bus.m0_req | bus.m1_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic last;  // port granted most recently

  always_comb begin
    pick = bus.m0_req ? 1'b0 : 1'b1;
    if (bus.m0_req && bus.m1_req) pick = ~last;
  end
`else
  always_comb begin
    pick = ~bus.m0_req;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= 1'b0;
      lat_we   <= 1'b0;
      lat_addr <= '0;
      lat_din  <= '0;
      rdata0   <= '0;
      rdata1   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last     <= 1'b1;
`endif
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) begin
        sel      <= pick;
        lat_we   <= pick ? bus.m1_we    : bus.m0_we;
        lat_addr <= pick ? bus.m1_addr  : bus.m0_addr;
        lat_din  <= pick ? bus.m1_wdata : bus.m0_wdata;
      end
      if (state == RESP && !lat_we) begin
        if (sel) rdata1 <= bus.ram_dout;
        else     rdata0 <= bus.ram_dout;
      end
`ifdef ARB_ROUND_ROBIN_EN
      if (state == ACCESS) last <= sel;
`endif
    end
  end

  // RAM address/data come straight from the latch so they hold between accesses
  assign bus.ram_addr = lat_addr;
  assign bus.ram_din  = lat_din;

  always_comb begin
    state_nxt     = state;
    bus.m0_gnt    = 1'b0;
    bus.m1_gnt    = 1'b0;
    bus.m0_rvalid = 1'b0;
    bus.m1_rvalid = 1'b0;
    bus.m0_rdata  = rdata0;
    bus.m1_rdata  = rdata1;
    bus.ram_we    = 1'b0;
    bus.busy      = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (any_req) state_nxt = ACCESS;
      end
      ACCESS: begin
        bus.ram_we = lat_we;
        bus.m0_gnt = ~sel;
        bus.m1_gnt = sel;
        state_nxt  = RESP;
      end
      RESP: begin
        // read data is forwarded in the RESP cycle, then held in the port register
        if (!lat_we) begin
          if (sel) begin
            bus.m1_rvalid = 1'b1;
            bus.m1_rdata  = bus.ram_dout;
          end else begin
            bus.m0_rvalid = 1'b1;
            bus.m0_rdata  = bus.ram_dout;
          end
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed accesses push expected grants/read data,
// a negedge monitor pops and compares whenever the arbiter pulses gnt or rvalid.
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  ram_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Registered-output RAM model, preloaded while reset is held
  logic [31:0] mem [1024];
  always @(posedge clk) begin
    if (rst) begin
      mem[10'h005] <= 32'hDEADBEEF;
      mem[10'h010] <= 32'hAAAA0010;
      mem[10'h020] <= 32'hBBBB0020;
    end else if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_din;
    end
    bus.ram_dout <= mem[bus.ram_addr];
  end

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int we_cnt = 0;
  int m1_rv_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          gnt_q [$];
  logic [31:0] rd0_q [$];
  logic [31:0] rd1_q [$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Monitor: compare every gnt/rvalid pulse against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ram_we) we_cnt++;
      if (bus.m1_rvalid) m1_rv_cnt++;
      if (bus.m0_gnt || bus.m1_gnt) begin
        check("gnt_onehot", 32'(bus.m0_gnt & bus.m1_gnt), 32'd0);
        if (gnt_q.size() == 0) check("gnt_unexpected", 32'(bus.m1_gnt), 32'hFFFF_FFFF);
        else                   check("gnt_port", 32'(bus.m1_gnt), 32'(gnt_q.pop_front()));
      end
      if (bus.m0_rvalid) begin
        if (rd0_q.size() == 0) check("m0_rvalid_unexpected", bus.m0_rdata, 32'hFFFF_FFFF);
        else                   check("m0_rdata", bus.m0_rdata, rd0_q.pop_front());
      end
      if (bus.m1_rvalid) begin
        if (rd1_q.size() == 0) check("m1_rvalid_unexpected", bus.m1_rdata, 32'hFFFF_FFFF);
        else                   check("m1_rdata", bus.m1_rdata, rd1_q.pop_front());
      end
    end
  end

  task automatic drive(input bit p, input logic r, input logic we,
                       input logic [9:0] a, input logic [31:0] d);
    if (p) begin
      bus.m1_req = r; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d;
    end else begin
      bus.m0_req = r; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d;
    end
  endtask

  task automatic set_req(input bit p, input logic r);
    if (p) bus.m1_req = r;
    else   bus.m0_req = r;
  endtask

  // One access from an idle arbiter; checks gnt at +1 and rvalid at +2 cycles
  task automatic access(input bit p, input logic we, input logic [9:0] a,
                        input logic [31:0] wd, input logic [31:0] exp, input bit sync);
    int c0;
    bit got;
    gnt_q.push_back(int'(p));
    if (!we) begin
      if (p) rd1_q.push_back(exp);
      else   rd0_q.push_back(exp);
    end
    if (sync) begin
      @(posedge clk);
      #1;
    end
    c0 = cyc;
    drive(p, 1'b1, we, a, wd);
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = p ? bus.m1_gnt : bus.m0_gnt;
    end
    if (!got) check("gnt_timeout", 32'd0, 32'd1);
    else      check("gnt_latency", 32'(cyc - c0), 32'd1);
    #1 set_req(p, 1'b0);
    @(negedge clk);
    if (!we) check("rvalid_latency", 32'(p ? bus.m1_rvalid : bus.m0_rvalid), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int c0;
    int n;
    bit got;
    bit p;
    drive(1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 10'h0, 32'h0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",     32'(bus.busy), 32'd0);
    check("rst_gnt",      32'({bus.m0_gnt, bus.m1_gnt}), 32'd0);
    check("rst_rvalid",   32'({bus.m0_rvalid, bus.m1_rvalid}), 32'd0);
    check("rst_ram_we",   32'(bus.ram_we), 32'd0);
    check("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    check("rst_ram_din",  bus.ram_din, 32'd0);
    check("rst_m0_rdata", bus.m0_rdata, 32'd0);
    check("rst_m1_rdata", bus.m1_rdata, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // m0 read issued in the very first cycle after reset release
    access(1'b0, 1'b0, 10'h005, 32'h0, 32'hDEADBEEF, 1'b0);
    check("m0_rdata_hold_beef", bus.m0_rdata, 32'hDEADBEEF);

    // m1 write to top address, then m0 reads it back
    we_cnt = 0;
    m1_rv_cnt = 0;
    access(1'b1, 1'b1, 10'h3FF, 32'h12345678, 32'h0, 1'b1);
    check("ram_we_cycles", 32'(we_cnt), 32'd1);
    check("hold_ram_addr", 32'(bus.ram_addr), 32'h3FF);
    check("hold_ram_din",  bus.ram_din, 32'h12345678);
    access(1'b0, 1'b0, 10'h3FF, 32'h0, 32'h12345678, 1'b1);
    check("raw_m0_rdata", bus.m0_rdata, 32'h12345678);
    check("m1_rvalid_on_write", 32'(m1_rv_cnt), 32'd0);
    check("ram_we_after_read", 32'(we_cnt), 32'd1);

    // per-port read data isolation
    access(1'b0, 1'b0, 10'h010, 32'h0, 32'hAAAA0010, 1'b1);
    access(1'b1, 1'b0, 10'h020, 32'h0, 32'hBBBB0020, 1'b1);
    check("iso_m0_rdata", bus.m0_rdata, 32'hAAAA0010);
    check("iso_m1_rdata", bus.m1_rdata, 32'hBBBB0020);

    // both ports request continuously
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      p = (k % 2 == 1);
`else
      p = 1'b0;
`endif
      gnt_q.push_back(int'(p));
      if (p) rd1_q.push_back(32'hBBBB0020);
      else   rd0_q.push_back(32'hDEADBEEF);
    end
    @(posedge clk);
    #1;
    c0 = cyc;
    drive(1'b0, 1'b1, 1'b0, 10'h005, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 10'h020, 32'h0);
    n = 0;
    for (int i = 0; i < 30 && n < 4; i++) begin
      @(negedge clk);
      if (bus.m0_gnt || bus.m1_gnt) begin
        check("contend_gnt_cycle", 32'(cyc - c0), 32'(1 + 3 * n));
        n++;
        if (n == 4) begin
          #1;
          set_req(1'b0, 1'b0);
          set_req(1'b1, 1'b0);
        end
      end
    end
    set_req(1'b0, 1'b0);
    set_req(1'b1, 1'b0);
    check("contend_grant_count", 32'(n), 32'd4);
    repeat (2) @(negedge clk);

    // reset during ACCESS of an m0 read aborts it
    gnt_q.push_back(0);
    @(posedge clk);
    #1 drive(1'b0, 1'b1, 1'b0, 10'h005, 32'h0);
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = bus.m0_gnt;
    end
    check("abort_gnt_seen", 32'(got), 32'd1);
    #1;
    set_req(1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy",      32'(bus.busy), 32'd0);
    check("abort_m0_rvalid", 32'(bus.m0_rvalid), 32'd0);
    check("abort_m0_rdata",  bus.m0_rdata, 32'd0);
    repeat (4) @(negedge clk);
    access(1'b0, 1'b0, 10'h005, 32'h0, 32'hDEADBEEF, 1'b1);
    check("after_abort_rdata", bus.m0_rdata, 32'hDEADBEEF);

    repeat (3) @(negedge clk);
    check("gnt_q_drained", 32'(gnt_q.size()), 32'd0);
    check("rd0_q_drained", 32'(rd0_q.size()), 32'd0);
    check("rd1_q_drained", 32'(rd1_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
